// File: rtl/temp_poll_sequencer.sv
// temp_poll_sequencer: command sequencer feeding i2c_master.
// Writes the sensor config once, then polls the temperature register.
// Ports: CLK/RES (sync active-low) clock and reset; en polling enable;
//   start/rw/adr/temp_reg_d1/temp_output_d2 command to the master;
//   m_busy/m_done/m_ack_err/m_rdata master status and read data;
//   temp_c/temp_valid signed reading; temp_error/fault error status.
module temp_poll_sequencer #(
  parameter logic [2:0]  DEV_ADR   = 3'b101,
  parameter logic [7:0]  CFG_PTR   = 8'h09,
  parameter logic [7:0]  CFG_VAL   = 8'h20,
  parameter logic [7:0]  TEMP_PTR  = 8'h00,
  parameter logic [15:0] PERIOD    = 16'd1000,
  parameter logic [15:0] TIMEOUT   = 16'd4000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       en,
  output logic       start,
  output logic       rw,
  output logic [2:0] adr,
  output logic [7:0] temp_reg_d1,
  output logic [7:0] temp_output_d2,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_ack_err,
  input  logic [7:0] m_rdata,
  output logic [8:0] temp_c,
  output logic       temp_valid,
  output logic [3:0] temp_error,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CFG_W,
    S_WAIT,
    S_RD,
    S_RD_W,
    S_RETRY,
    S_FAULT
  } state_t;

  localparam logic EXT = CFG_VAL[2];

  state_t state, state_d, retry_nxt;

  // Shared counter: transaction timer in the *_W states,
  // period counter in S_WAIT / S_RETRY.
  logic [15:0] cnt;
  logic [1:0]  retry_cnt;
  logic        wait_st;
  logic        ok;
  logic        fail;
  logic        cnt_done;
  logic [8:0]  conv;

  assign adr = DEV_ADR;

  always_comb begin
    wait_st  = (state == S_CFG_W) || (state == S_RD_W);
    ok       = wait_st && m_done && !m_ack_err;
    // m_done on the expiry cycle wins over the timeout
    fail     = wait_st &&
               ((m_done && m_ack_err) ||
                (!m_done && (cnt == TIMEOUT)));
    cnt_done = (cnt >= (PERIOD - 16'd1));
    if (EXT)
      conv = {1'b0, m_rdata} - 9'd64;
    else
      conv = {m_rdata[7], m_rdata};
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      S_IDLE:
        if (en && !m_busy) state_d = S_CFG;
      S_CFG:
        if (!m_busy) begin
          start   = 1'b1;
          state_d = S_CFG_W;
        end
      S_CFG_W, S_RD_W:
        if (ok)        state_d = S_WAIT;
        else if (fail) state_d = S_RETRY;
      S_WAIT:
        if (cnt_done && en && !m_busy)
          state_d = S_RD;
      S_RD:
        if (!m_busy) begin
          start   = 1'b1;
          state_d = S_RD_W;
        end
      S_RETRY:
        if (retry_cnt == MAX_RETRY)
          state_d = S_FAULT;
        else if (cnt_done)
          state_d = retry_nxt;
      S_FAULT:
        state_d = S_FAULT;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state          <= S_IDLE;
      retry_nxt      <= S_CFG;
      cnt            <= 16'd0;
      retry_cnt      <= 2'd0;
      rw             <= 1'b0;
      temp_reg_d1    <= 8'h00;
      temp_output_d2 <= 8'h00;
      temp_c         <= 9'd0;
      temp_valid     <= 1'b0;
      temp_error     <= 4'd0;
      fault          <= 1'b0;
    end else begin
      state      <= state_d;
      temp_valid <= 1'b0;

      // The cycle carrying start counts as the first timed cycle.
      if (start || ok || fail)
        cnt <= 16'd1;
      else if (wait_st)
        cnt <= cnt + 16'd1;
      else if ((state == S_WAIT || state == S_RETRY) && !cnt_done)
        cnt <= cnt + 16'd1;

      if (ok)
        retry_cnt <= 2'd0;

      if (fail) begin
        retry_cnt <= retry_cnt + 2'd1;
        if (temp_error != 4'hF)
          temp_error <= temp_error + 4'd1;
        retry_nxt <= (state == S_CFG_W) ? S_CFG : S_RD;
      end

      if (ok && state == S_RD_W) begin
        temp_c     <= conv;
        temp_valid <= 1'b1;
      end

      // Command fields settle on entry and hold until m_done.
      if (state_d == S_CFG && state != S_CFG) begin
        rw             <= 1'b0;
        temp_reg_d1    <= CFG_PTR;
        temp_output_d2 <= CFG_VAL;
      end
      if (state_d == S_RD && state != S_RD) begin
        rw             <= 1'b1;
        temp_reg_d1    <= TEMP_PTR;
        temp_output_d2 <= 8'h00;
      end

      if (state_d == S_FAULT)
        fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_temp_poll_sequencer.sv
// tb_temp_poll_sequencer: scoreboard bench for temp_poll_sequencer.
// Two instances share stimulus; the second uses the extended range.
module tb_temp_poll_sequencer;

  logic       CLK = 1'b0;
  logic       RES;
  logic       en;
  logic       m_busy;
  logic       m_done;
  logic       m_ack_err;
  logic [7:0] m_rdata;

  logic       start, rw, temp_valid, fault;
  logic [2:0] adr;
  logic [7:0] temp_reg_d1, temp_output_d2;
  logic [8:0] temp_c;
  logic [3:0] temp_error;

  logic       start_b, rw_b, temp_valid_b, fault_b;
  logic [2:0] adr_b;
  logic [7:0] temp_reg_d1_b, temp_output_d2_b;
  logic [8:0] temp_c_b;
  logic [3:0] temp_error_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [19:0] qs1[$];
  logic [19:0] qs2[$];
  logic [8:0]  qt1[$];
  logic [8:0]  qt2[$];
  logic [19:0] last1 = '0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  temp_poll_sequencer dut (
    .CLK(CLK), .RES(RES), .en(en),
    .start(start), .rw(rw), .adr(adr),
    .temp_reg_d1(temp_reg_d1),
    .temp_output_d2(temp_output_d2),
    .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata),
    .temp_c(temp_c), .temp_valid(temp_valid),
    .temp_error(temp_error), .fault(fault)
  );

  temp_poll_sequencer #(.CFG_VAL(8'h24)) dut_b (
    .CLK(CLK), .RES(RES), .en(en),
    .start(start_b), .rw(rw_b), .adr(adr_b),
    .temp_reg_d1(temp_reg_d1_b),
    .temp_output_d2(temp_output_d2_b),
    .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata),
    .temp_c(temp_c_b), .temp_valid(temp_valid_b),
    .temp_error(temp_error_b), .fault(fault_b)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got an output, expected none", nm);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents output.
  always @(negedge CLK) begin
    if (start) begin
      if (qs1.size() == 0) unexp("start_a");
      else begin
        last1 = qs1.pop_front();
        chk("start_a",
            {rw, adr, temp_reg_d1, temp_output_d2}, last1);
      end
    end
    if (start_b) begin
      if (qs2.size() == 0) unexp("start_b");
      else
        chk("start_b",
            {rw_b, adr_b, temp_reg_d1_b, temp_output_d2_b},
            qs2.pop_front());
    end
    if (temp_valid) begin
      if (qt1.size() == 0) unexp("temp_a");
      else chk("temp_a", temp_c, qt1.pop_front());
    end
    if (temp_valid_b) begin
      if (qt2.size() == 0) unexp("temp_b");
      else chk("temp_b", temp_c_b, qt2.pop_front());
    end
  end

  task automatic exp_start(input logic r, input logic [7:0] ptr);
    qs1.push_back({r, 3'b101, ptr, r ? 8'h00 : 8'h20});
    qs2.push_back({r, 3'b101, ptr, r ? 8'h00 : 8'h24});
  endtask

  task automatic exp_temp(input logic [8:0] e1,
                          input logic [8:0] e2);
    qt1.push_back(e1);
    qt2.push_back(e2);
  endtask

  task automatic wait_start(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic serve(input int dly, input logic err,
                       input logic [7:0] rd, output int d);
    repeat (dly) @(negedge CLK);
    m_done    = 1'b1;
    m_ack_err = err;
    m_rdata   = rd;
    d         = cyc;
    chk("hold", {rw, adr, temp_reg_d1, temp_output_d2}, last1);
    @(negedge CLK);
    m_done    = 1'b0;
    m_ack_err = 1'b0;
  endtask

  task automatic read_ok(input logic [7:0] rd,
                         input logic [8:0] e1,
                         input logic [8:0] e2,
                         input int prev, output int d);
    int s;
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("period", s - prev, 1000);
    exp_temp(e1, e2);
    serve(2, 1'b0, rd, d);
  endtask

  task automatic chk_clear(input string nm);
    chk(nm, {start, rw, adr, temp_reg_d1, temp_output_d2,
             temp_c, temp_valid, temp_error, fault},
        {1'b0, 1'b0, 3'b101, 8'h00, 8'h00,
         9'h000, 1'b0, 4'h0, 1'b0});
  endtask

  initial begin
    int s, s2, d;
    RES = 1'b0; en = 1'b0; m_busy = 1'b0;
    m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
    repeat (3) @(negedge CLK);
    chk_clear("reset_a");
    chk("reset_b", {start_b, temp_c_b, temp_error_b, fault_b}, 0);

    RES = 1'b1; en = 1'b1;
    exp_start(1'b0, 8'h09);
    wait_start(10, s);
    chk("cfg_seen", s >= 0, 1);
    serve(3, 1'b0, 8'h00, d);

    read_ok(8'h19, 9'h019, 9'h1D9, d, d);
    read_ok(8'h40, 9'h040, 9'h000, d, d);
    read_ok(8'h00, 9'h000, 9'h1C0, d, d);
    read_ok(8'hF0, 9'h1F0, 9'h0B0, d, d);

    // master busy when the read falls due
    @(negedge CLK); m_busy = 1'b1;
    while (cyc < d + 1200) @(negedge CLK);
    m_busy = 1'b0;
    exp_start(1'b1, 8'h00);
    wait_start(10, s);
    chk("busy_release", s, d + 1201);
    exp_temp(9'h019, 9'h1D9);
    serve(2, 1'b0, 8'h19, d);

    // polling disabled while waiting
    @(negedge CLK); en = 1'b0;
    while (cyc < d + 1500) @(negedge CLK);
    en = 1'b1;
    exp_start(1'b1, 8'h00);
    wait_start(10, s);
    chk("en_resume", s, d + 1501);
    exp_temp(9'h005, 9'h1C5);
    serve(2, 1'b0, 8'h05, d);

    // no response: timeout then retry
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("period_to", s - d, 1000);
    while (cyc < s + 4000) @(negedge CLK);
    chk("err_pre_to", temp_error, 0);
    @(negedge CLK);
    chk("err_post_to", temp_error, 1);
    exp_start(1'b1, 8'h00);
    wait_start(1100, s2);
    chk("retry_gap", s2 - s, 5000);

    // m_done on the expiry cycle is a success
    exp_temp(9'h01E, 9'h1DE);
    serve(4000, 1'b0, 8'h1E, d);
    chk("coinc_err", temp_error, 1);

    // reset in the middle of a read, then a stale m_done
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("period_rst", s - d, 1000);
    @(negedge CLK); m_busy = 1'b1;
    @(negedge CLK); RES = 1'b0;
    @(negedge CLK); RES = 1'b1;
    chk_clear("reset_mid");
    m_done = 1'b1; m_ack_err = 1'b1; m_rdata = 8'hAA;
    @(negedge CLK);
    m_done = 1'b0; m_ack_err = 1'b0;
    @(negedge CLK); m_busy = 1'b0;
    exp_start(1'b0, 8'h09);
    wait_start(10, s);
    chk("cfg_again", s >= 0, 1);
    chk("stale_err", temp_error, 0);
    serve(2, 1'b0, 8'h00, d);

    // three NACKed reads in a row
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("period_f", s - d, 1000);
    serve(2, 1'b1, 8'h00, d);
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("retry1", s - d, 1000);
    serve(2, 1'b1, 8'h00, d);
    exp_start(1'b1, 8'h00);
    wait_start(1100, s);
    chk("retry2", s - d, 1000);
    serve(2, 1'b1, 8'h00, d);
    repeat (3) @(negedge CLK);
    chk("fault", fault, 1);
    chk("fault_err", temp_error, 3);
    wait_start(10000, s);
    chk("fault_quiet", s, -1);
    chk("fault_hold", fault, 1);

    @(negedge CLK); RES = 1'b0;
    @(negedge CLK); RES = 1'b1;
    chk_clear("reset_fault");
    exp_start(1'b0, 8'h09);
    wait_start(10, s);
    chk("cfg_after_fault", s >= 0, 1);

    repeat (5) @(negedge CLK);
    chk("sb_empty",
        qs1.size() + qs2.size() + qt1.size() + qt2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
